timer_ctrl: RTL and testbench

//  Sequencer for the 3-digit BCD countdown timer datapath (ones/tens/hundreds down-counter chain).

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_ctrl_tick_gen.sv | 39 +++
 rtl/timer_ctrl.sv | 146 ++++++++++++++
 tb/tb_timer_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 3-digit BCD countdown timer sequencer:
// state encodings, digit geometry and a BCD range check.
package timer_pkg;

  localparam int BCD_W    = 4;
  localparam int DIGITS   = 3;
  localparam int PRESET_W = BCD_W * DIGITS;

  // Encodings are visible on STATE_O (LEDs), so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  // True when every nibble of a {hundreds,tens,ones} word is a legal BCD digit.
  function automatic logic bcd_valid(input logic [PRESET_W-1:0] val);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (val[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler for the timer sequencer. Counts 0..CLK_DIV-1 while enabled,
// holds its value while disabled, and clears on request (clear wins).
// o_wrap flags the last count of a period while counting is enabled.
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  // Decoded from the count register only, so no input-to-output path
  // other than the enable qualifier.
  assign o_wrap   = i_en && w_at_max;

  // Prescaler count: clear has priority, then wrap-around or increment.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours; = here would create
    // order-dependent simulation and a mismatch against synthesis.
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencer for the 3-digit BCD countdown timer. Owns the preset register,
// the run/pause/alarm FSM and the alarm duration counter; the prescaler
// lives in tick_gen. All outputs come straight from registers.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int                  CLK_DIV    = 50_000_000,
  parameter int                  ALARM_SEC  = 5,
  parameter logic [PRESET_W-1:0] PRESET_DEF = 12'h020
) (
  input  logic                CLK_I,
  input  logic                SW_RESET_I,
  input  logic                START_I,
  input  logic                STOP_I,
  input  logic                PAUSE_I,
  input  logic                SET_I,
  input  logic [PRESET_W-1:0] SET_VAL_I,
  input  logic [BCD_W-1:0]    TIM_1_I,
  input  logic [BCD_W-1:0]    TIM_2_I,
  input  logic [BCD_W-1:0]    TIM_3_I,
  output logic                LOAD_O,
  output logic [PRESET_W-1:0] PRESET_O,
  output logic                PULSE_1SEC_O,
  output logic                TIMEOUT_O,
  output logic                ALARM_O,
  output logic [2:0]          STATE_O
);

  localparam int               ACNT_W     = $clog2(ALARM_SEC + 1);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_SEC - 1);

  state_t              r_state;
  logic [PRESET_W-1:0] r_preset;
  logic [ACNT_W-1:0]   r_alarm_cnt;
  logic                r_load;
  logic                r_pulse;
  logic                r_alarm;

  logic w_digits_zero;
  logic w_presc_en;
  logic w_presc_clr;
  logic w_wrap;

  assign w_digits_zero = ({TIM_3_I, TIM_2_I, TIM_1_I} == '0);

  // The prescaler advances only while seconds are being counted (RUN) or
  // the alarm is being timed (ALARM); in PAUSE it simply holds.
  assign w_presc_en = (r_state == ST_RUN) || (r_state == ST_ALARM);

  // Clear whenever the next period must start from zero: idle/load, abort,
  // entry into ALARM from RUN, and alarm acknowledge.
  assign w_presc_clr = STOP_I
                    || (r_state == ST_IDLE)
                    || (r_state == ST_LOAD)
                    || ((r_state == ST_RUN)   && w_digits_zero)
                    || ((r_state == ST_ALARM) && START_I);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk   (CLK_I),
    .i_rst_n (SW_RESET_I),
    .i_en    (w_presc_en),
    .i_clr   (w_presc_clr),
    .o_wrap  (w_wrap)
  );

  // Preset register: only accepts a fully valid BCD word, and only in IDLE.
  always_ff @(posedge CLK_I) begin
    if (!SW_RESET_I) begin
      r_preset <= PRESET_DEF;
    end else if ((r_state == ST_IDLE) && SET_I && bcd_valid(SET_VAL_I)) begin
      r_preset <= SET_VAL_I;
    end
  end

  // Control FSM with registered strobes; STOP overrides everything,
  // otherwise START beats PAUSE wherever both have a meaning.
  always_ff @(posedge CLK_I) begin
    if (!SW_RESET_I) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= '0;
      r_load      <= 1'b0;
      r_pulse     <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      // NOTE: the strobes are set on the edge that enters the state they
      // belong to, so they line up with STATE_O without a decoder glitch.
      r_load  <= 1'b0;
      r_pulse <= 1'b0;
      if (STOP_I) begin
        r_state     <= ST_IDLE;
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START_I) begin
              r_state <= ST_LOAD;
              r_load  <= 1'b1;
            end
          end
          ST_LOAD: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_digits_zero) begin
              r_state     <= ST_ALARM;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= '0;
            end else begin
              // A second completing on the same edge as a pause is still
              // delivered, so no partial time is lost.
              r_pulse <= w_wrap;
              if (PAUSE_I) r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (START_I || PAUSE_I) r_state <= ST_RUN;
          end
          ST_ALARM: begin
            if (START_I || (w_wrap && (r_alarm_cnt == ALARM_LAST))) begin
              r_state     <= ST_IDLE;
              r_alarm     <= 1'b0;
              r_alarm_cnt <= '0;
            end else if (w_wrap) begin
              r_alarm_cnt <= r_alarm_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LOAD_O       = r_load;
  assign PRESET_O     = r_preset;
  assign PULSE_1SEC_O = r_pulse;
  assign TIMEOUT_O    = r_alarm;
  assign ALARM_O      = r_alarm;
  assign STATE_O      = r_state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural BCD down-counter chain.
// Stimulus pushes the expected output events (load, tick, alarm on/off) with
// their hand-computed cycle numbers; a monitor pops and compares them.
module tb_timer_ctrl;

  typedef enum int {EV_LOAD = 0, EV_TICK = 1, EV_ALARM_ON = 2, EV_ALARM_OFF = 3} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [11:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0, set = 1'b0;
  logic [11:0] set_val = 12'h000;
  logic [3:0]  m_d1 = 4'd0, m_d2 = 4'd0, m_d3 = 4'd0;
  logic        load_o, pulse_o, timeout_o, alarm_o;
  logic [11:0] preset_o;
  logic [2:0]  state_o;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  logic mon_prev_alarm = 1'b0;
  ev_t exp_q[$];

  timer_ctrl #(
    .CLK_DIV    (4),
    .ALARM_SEC  (2),
    .PRESET_DEF (12'h020)
  ) dut (
    .CLK_I        (clk),
    .SW_RESET_I   (rst_n),
    .START_I      (start),
    .STOP_I       (stop),
    .PAUSE_I      (pause),
    .SET_I        (set),
    .SET_VAL_I    (set_val),
    .TIM_1_I      (m_d1),
    .TIM_2_I      (m_d2),
    .TIM_3_I      (m_d3),
    .LOAD_O       (load_o),
    .PRESET_O     (preset_o),
    .PULSE_1SEC_O (pulse_o),
    .TIMEOUT_O    (timeout_o),
    .ALARM_O      (alarm_o),
    .STATE_O      (state_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] o, t, h;
    {h, t, o} = v;
    if (o != 4'd0) o = o - 4'd1;
    else begin
      o = 4'd9;
      if (t != 4'd0) t = t - 4'd1;
      else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, o};
  endfunction

  // Cycle counter and behavioural counter chain.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_o === 1'b1) {m_d3, m_d2, m_d1} <= preset_o;
    else if (pulse_o === 1'b1) {m_d3, m_d2, m_d1} <= bcd_dec({m_d3, m_d2, m_d1});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input logic [11:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic report(input ev_kind_t k, input logic [11:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event cyc=%0d actual_kind=%0d data=%0h expected=none", cyc, k, d);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      check("ev_cycle", 32'(cyc), 32'(e.cyc));
      check("ev_data", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (load_o === 1'b1)  report(EV_LOAD, preset_o);
      if (pulse_o === 1'b1) report(EV_TICK, {m_d3, m_d2, m_d1});
      if (alarm_o === 1'b1 && mon_prev_alarm !== 1'b1) report(EV_ALARM_ON, {9'd0, state_o});
      if (alarm_o === 1'b0 && mon_prev_alarm === 1'b1) report(EV_ALARM_OFF, {9'd0, state_o});
      mon_prev_alarm = alarm_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic do_set(input logic [11:0] v);
    set_val = v;
    set = 1'b1;
    step(1);
    set = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, 32'(load_o), 0);
    check({tag, "_pulse"}, 32'(pulse_o), 0);
    check({tag, "_timeout"}, 32'(timeout_o), 0);
    check({tag, "_alarm"}, 32'(alarm_o), 0);
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_preset"}, 32'(preset_o), 32'h020);
  endtask

  initial begin
    int c;
    // Reset
    step(3);
    check_reset_outputs("por");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Invalid BCD words are ignored in IDLE
    do_set(12'h0A5);
    check("set_invalid_tens", 32'(preset_o), 32'h020);
    do_set(12'h90F);
    check("set_invalid_ones", 32'(preset_o), 32'h020);

    // Full countdown from 003 through alarm timeout
    do_set(12'h003);
    check("set_valid", 32'(preset_o), 32'h003);
    c = cyc;
    push(EV_LOAD, c + 1, 12'h003);
    push(EV_TICK, c + 6, 12'h003);
    push(EV_TICK, c + 10, 12'h002);
    push(EV_TICK, c + 14, 12'h001);
    push(EV_ALARM_ON, c + 16, 12'h004);
    push(EV_ALARM_OFF, c + 24, 12'h000);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("load_state", 32'(state_o), 1);
    wait_until(c + 8);
    check("run_state", 32'(state_o), 2);
    do_set(12'h007);
    check("set_in_run_ignored", 32'(preset_o), 32'h003);
    wait_until(c + 20);
    check("alarm_timeout", 32'(timeout_o), 1);
    check("alarm_state", 32'(state_o), 4);
    wait_until(c + 26);
    check("post_alarm_state", 32'(state_o), 0);
    check("post_alarm_timeout", 32'(timeout_o), 0);

    // Pause keeps the partial second; STOP beats START in RUN
    do_set(12'h005);
    c = cyc;
    push(EV_LOAD, c + 1, 12'h005);
    push(EV_TICK, c + 17, 12'h005);
    push(EV_TICK, c + 21, 12'h004);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 3);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("pause_state", 32'(state_o), 3);
    wait_until(c + 14);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("resume_state", 32'(state_o), 2);
    wait_until(c + 23);
    stop = 1'b1;
    start = 1'b1;
    step(1);
    stop = 1'b0;
    start = 1'b0;
    check("stop_start_state", 32'(state_o), 0);
    check("stop_start_no_load", 32'(load_o), 0);
    step(6);

    // Preset 000: straight to alarm without ticks; START acknowledges
    do_set(12'h000);
    c = cyc;
    push(EV_LOAD, c + 1, 12'h000);
    push(EV_ALARM_ON, c + 3, 12'h004);
    push(EV_ALARM_OFF, c + 6, 12'h000);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("ack_state", 32'(state_o), 0);
    step(4);

    // Reset mid-RUN
    do_set(12'h002);
    c = cyc;
    push(EV_LOAD, c + 1, 12'h002);
    push(EV_TICK, c + 6, 12'h002);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 7);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_reset_outputs("rst_run");
    step(6);

    // Reset mid-ALARM
    do_set(12'h000);
    c = cyc;
    push(EV_LOAD, c + 1, 12'h000);
    push(EV_ALARM_ON, c + 3, 12'h004);
    push(EV_ALARM_OFF, c + 6, 12'h000);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_until(c + 5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_reset_outputs("rst_alarm");
    step(10);

    check("events_outstanding", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
